// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and RAM port of the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM-side view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  // Instruction fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  // Data load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // RAM port
  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  // Timeout indication
  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_ready,
    output if_ack, if_rdata, d_ack, d_rdata, ram_cs, ram_we, ram_addr, ram_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, ram_cs, ram_we, ram_addr, ram_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one single-ported RAM.
// One access at a time; acks are registered; a wait counter bounds each access.
// Build option MEM_ARBITER_RR_EN: ties are broken round-robin instead of data-first.
// Assumes DATA_W >= 64 (fetch selects a 32-bit half of the low 64 bits).
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic if_elig, d_elig;
  logic gnt_if, gnt_d;
  logic busy, timeout;

`ifdef MEM_ARBITER_RR_EN
  logic last_fetch_q, last_fetch_d;
`endif

  assign busy    = (state_q != StIdle);
  assign timeout = ~bus.ram_ready && (cnt_q == CntW'(TIMEOUT - 1));

  // Grant selection; a requester being acked this cycle still holds req but is done.
  always_comb begin
    if_elig = bus.if_req & ~if_ack_q;
    d_elig  = bus.d_req & ~d_ack_q;
`ifdef MEM_ARBITER_RR_EN
    gnt_d   = d_elig & (~if_elig | last_fetch_q);
`else
    gnt_d   = d_elig;
`endif
    gnt_if  = if_elig & ~gnt_d;
  end

`ifdef MEM_ARBITER_RR_EN
  // Track the winner of the most recent grant so the next tie goes the other way.
  always_comb begin
    last_fetch_d = last_fetch_q;
    if (state_q == StIdle && (gnt_if || gnt_d)) begin
      last_fetch_d = gnt_if;
    end
  end

  // Round-robin pointer; resets to "fetch won last" so the first tie goes to data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_fetch_q <= 1'b1;
    end else begin
      last_fetch_q <= last_fetch_d;
    end
  end
`endif

  // Next-state logic: grant in idle, wait for ready or timeout while busy.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_d) begin
          state_d = StData;
          addr_d  = bus.d_addr;
          we_d    = bus.d_we;
          wdata_d = bus.d_wdata;
          cnt_d   = '0;
        end else if (gnt_if) begin
          state_d = StFetch;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          cnt_d   = '0;
        end
      end
      StFetch, StData: begin
        if (bus.ram_ready || timeout) begin
          state_d = StIdle;
          err_d   = timeout;
          if (state_q == StFetch) begin
            if_ack_d = 1'b1;
            if (timeout) begin
              if_rdata_d = '0;
            end else begin
              if_rdata_d = addr_q[2] ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0];
            end
          end else begin
            d_ack_d = 1'b1;
            // Stores leave the previous load data in place.
            if (!we_q) begin
              d_rdata_d = timeout ? '0 : bus.ram_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset drops any in-flight access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // RAM drive is a pure function of state so reset clears it without waiting for a clock.
  always_comb begin
    bus.ram_cs    = busy;
    bus.ram_we    = (state_q == StData) && we_q;
    bus.ram_addr  = busy ? addr_q : '0;
    bus.ram_wdata = (state_q == StData) ? wdata_q : '0;
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.err      = err_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule
